pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage MIPS pipeline.
//  - Drives enable/flush of the IF/ID, ID/EX, EX/MEM and MEM/WB latches, plus the PC write enable.
//  - Resolves cache waits, load-use hazards and taken control transfers resolved in MEM.
//  - Runs the halt-drain sequence that ends with a sticky halt.

---
 rtl/pipeline_hazard_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: latch enables/flushes, PC enable, halt-drain FSM.
// Latency: control outputs are combinational from inputs and state; halt rises DRAIN_CYCLES+1 edges after halt_MEM.
// Backpressure: a pending dcache access freezes PC..EX/MEM and bubbles WB. Perf counters need HAZARD_PERF_EN.
module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmem_req_MEM,
    input  logic             memtoReg_EX,
    input  logic [4:0]       final_wsel_EX,
    input  logic [4:0]       rs_ID,
    input  logic [4:0]       rt_ID,
    input  logic             redirect_MEM,
    input  logic             halt_MEM,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic             memwb_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] DRAIN  = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    // Drain counter holds values 0..DRAIN_CYCLES-1.
    localparam int DCW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

    logic [1:0]     state;
    logic [DCW-1:0] drain_cnt;
    logic           dwait;
    logic           lduse;

    assign dwait = dmem_req_MEM & ~dhit;
    assign lduse = memtoReg_EX & (final_wsel_EX != 5'd0) &
                   ((final_wsel_EX == rs_ID) | (final_wsel_EX == rt_ID));

    assign halt = (state == HALTED);

    // Latch control: reset and HALTED flush everything, RUN applies hazard priority, DRAIN retires MEM/WB only.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_flush  = 1'b0;
        exmem_en    = 1'b0;
        exmem_flush = 1'b0;
        memwb_en    = 1'b0;
        memwb_flush = 1'b0;
        if (RST || state == HALTED || state == 2'd3) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (state == DRAIN || (!dwait && halt_MEM)) begin
            // Drain (and its entry cycle): front end held in flush while MEM/WB retires.
            ifid_en     = 1'b1;
            ifid_flush  = 1'b1;
            idex_en     = 1'b1;
            idex_flush  = 1'b1;
            exmem_en    = 1'b1;
            exmem_flush = 1'b1;
            memwb_en    = 1'b1;
        end else if (dwait) begin
            // Freeze everything upstream of WB; redirect stays held in EX/MEM until dhit.
            memwb_en    = 1'b1;
            memwb_flush = 1'b1;
        end else if (redirect_MEM) begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            ifid_flush  = 1'b1;
            idex_en     = 1'b1;
            idex_flush  = 1'b1;
            exmem_en    = 1'b1;
            exmem_flush = 1'b1;
            memwb_en    = 1'b1;
        end else if (lduse) begin
            // IF/ID frozen (not flushed) even when ihit is low, so the fetched word survives.
            idex_en     = 1'b1;
            idex_flush  = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
        end else if (!ihit) begin
            ifid_en     = 1'b1;
            ifid_flush  = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
        end else begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
        end
    end

    // Halt-drain FSM: enter DRAIN once MEM is not waiting, count down, then stick in HALTED until reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (halt_MEM && !dwait) begin
                        state     <= DRAIN;
                        drain_cnt <= DCW'(DRAIN_CYCLES - 1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= HALTED;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                default: state <= HALTED;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic             stall_evt;
    logic             flush_evt;

    assign stall_evt = (state == RUN) && !pc_en && !redirect_MEM;
    assign flush_evt = (state == RUN) && redirect_MEM && !dwait;

    // Saturating perf counters; only RUN cycles can raise an event, so they hold in DRAIN/HALTED.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_evt && stall_q != {CNT_W{1'b1}}) stall_q <= stall_q + 1'b1;
            if (flush_evt && flush_q != {CNT_W{1'b1}}) flush_q <= flush_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (DRAIN_CYCLES=2, CNT_W=4).
// Inputs change 1ns after the rising edge; combinational outputs are sampled 1ns later.
// Counter expectations follow HAZARD_PERF_EN as seen by this compile.
module tb_pipeline_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       ihit, dhit, dmem_req_MEM, memtoReg_EX, redirect_MEM, halt_MEM;
    logic [4:0] final_wsel_EX, rs_ID, rt_ID;
    logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic       exmem_en, exmem_flush, memwb_en, memwb_flush, halt;
    logic [3:0] stall_cnt, flush_cnt;
    logic [8:0] ctl;

    int checks = 0;
    int passed = 0;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush}
    localparam logic [8:0] C_RESET  = 9'b001010101;
    localparam logic [8:0] C_NORM   = 9'b110101010;
    localparam logic [8:0] C_DWAIT  = 9'b000000011;
    localparam logic [8:0] C_REDIR  = 9'b111111110;
    localparam logic [8:0] C_LDUSE  = 9'b000111010;
    localparam logic [8:0] C_NOIHIT = 9'b011101010;
    localparam logic [8:0] C_DRAIN  = 9'b011111110;

`ifdef HAZARD_PERF_EN
    localparam logic [3:0] E_STALL3  = 4'd3;
    localparam logic [3:0] E_STALL20 = 4'd15;
    localparam logic [3:0] E_FLUSH2  = 4'd2;
`else
    localparam logic [3:0] E_STALL3  = 4'd0;
    localparam logic [3:0] E_STALL20 = 4'd0;
    localparam logic [3:0] E_FLUSH2  = 4'd0;
`endif

    assign ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                  exmem_en, exmem_flush, memwb_en, memwb_flush};

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(2), .CNT_W(4)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmem_req_MEM(dmem_req_MEM),
        .memtoReg_EX(memtoReg_EX), .final_wsel_EX(final_wsel_EX), .rs_ID(rs_ID), .rt_ID(rt_ID),
        .redirect_MEM(redirect_MEM), .halt_MEM(halt_MEM), .pc_en(pc_en),
        .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .exmem_flush(exmem_flush), .memwb_en(memwb_en),
        .memwb_flush(memwb_flush), .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0; dmem_req_MEM = 1'b0; memtoReg_EX = 1'b0;
        final_wsel_EX = 5'd0; rs_ID = 5'd0; rt_ID = 5'd0;
        redirect_MEM = 1'b0; halt_MEM = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle();
        RST = 1'b1;
        tick();
        tick();
        checks++; if (ctl !== C_RESET) $display("FAIL reset_ctl: got %b expected %b", ctl, C_RESET); else passed++;
        checks++; if (halt !== 1'b0) $display("FAIL reset_halt: got %b expected 0", halt); else passed++;
        checks++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0)
            $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); else passed++;
        RST = 1'b0;
        #1;
        checks++; if (ctl !== C_NORM) $display("FAIL first_run: got %b expected %b", ctl, C_NORM); else passed++;
        tick();
    endtask

    task automatic test_lduse();
        idle();
        memtoReg_EX = 1'b1; final_wsel_EX = 5'd5; rs_ID = 5'd5; rt_ID = 5'd3;
        #1;
        checks++; if (ctl !== C_LDUSE) $display("FAIL lduse_rs: got %b expected %b", ctl, C_LDUSE); else passed++;
        tick();
        memtoReg_EX = 1'b0;
        #1;
        checks++; if (ctl !== C_NORM) $display("FAIL lduse_one_bubble: got %b expected %b", ctl, C_NORM); else passed++;
        tick();
        memtoReg_EX = 1'b1; final_wsel_EX = 5'd7; rs_ID = 5'd1; rt_ID = 5'd7;
        #1;
        checks++; if (ctl !== C_LDUSE) $display("FAIL lduse_rt: got %b expected %b", ctl, C_LDUSE); else passed++;
        tick();
        final_wsel_EX = 5'd0; rs_ID = 5'd0; rt_ID = 5'd0;
        #1;
        checks++; if (ctl !== C_NORM) $display("FAIL lduse_r0: got %b expected %b", ctl, C_NORM); else passed++;
        tick();
        final_wsel_EX = 5'd5; rs_ID = 5'd6; rt_ID = 5'd4;
        #1;
        checks++; if (ctl !== C_NORM) $display("FAIL lduse_nomatch: got %b expected %b", ctl, C_NORM); else passed++;
        tick();
        idle();
    endtask

    task automatic test_ihit();
        idle();
        ihit = 1'b0;
        #1;
        checks++; if (ctl !== C_NOIHIT) $display("FAIL noihit: got %b expected %b", ctl, C_NOIHIT); else passed++;
        tick();
        memtoReg_EX = 1'b1; final_wsel_EX = 5'd9; rs_ID = 5'd9;
        #1;
        checks++; if (ctl !== C_LDUSE) $display("FAIL lduse_noihit: got %b expected %b", ctl, C_LDUSE); else passed++;
        tick();
        idle();
    endtask

    task automatic test_dwait_redirect();
        idle();
        dmem_req_MEM = 1'b1; dhit = 1'b0; redirect_MEM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ctl !== C_DWAIT) $display("FAIL dwait_cyc%0d: got %b expected %b", i, ctl, C_DWAIT); else passed++;
            tick();
        end
        dhit = 1'b1;
        #1;
        checks++; if (ctl !== C_REDIR) $display("FAIL dwait_release: got %b expected %b", ctl, C_REDIR); else passed++;
        tick();
        idle();
    endtask

    task automatic test_redirect_priority();
        idle();
        redirect_MEM = 1'b1; ihit = 1'b0;
        memtoReg_EX = 1'b1; final_wsel_EX = 5'd4; rs_ID = 5'd4;
        #1;
        checks++; if (ctl !== C_REDIR) $display("FAIL redirect_prio: got %b expected %b", ctl, C_REDIR); else passed++;
        tick();
        idle();
    endtask

    task automatic test_counters();
        do_reset();
        ihit = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (stall_cnt !== E_STALL3) $display("FAIL stall_cnt_3: got %0d expected %0d", stall_cnt, E_STALL3); else passed++;
        for (int i = 0; i < 17; i++) tick();
        checks++; if (stall_cnt !== E_STALL20) $display("FAIL stall_cnt_sat: got %0d expected %0d", stall_cnt, E_STALL20); else passed++;
        ihit = 1'b1; redirect_MEM = 1'b1;
        tick();
        tick();
        redirect_MEM = 1'b0;
        #1;
        checks++; if (flush_cnt !== E_FLUSH2) $display("FAIL flush_cnt: got %0d expected %0d", flush_cnt, E_FLUSH2); else passed++;
        checks++; if (stall_cnt !== E_STALL20) $display("FAIL stall_cnt_hold: got %0d expected %0d", stall_cnt, E_STALL20); else passed++;
        idle();
    endtask

    task automatic test_halt();
        do_reset();
        halt_MEM = 1'b1; dmem_req_MEM = 1'b1; dhit = 1'b0;
        #1;
        checks++; if (ctl !== C_DWAIT) $display("FAIL halt_dwait: got %b expected %b", ctl, C_DWAIT); else passed++;
        tick();
        dhit = 1'b1;
        #1;
        checks++; if (ctl !== C_DRAIN) $display("FAIL halt_entry: got %b expected %b", ctl, C_DRAIN); else passed++;
        tick();
        idle();
        redirect_MEM = 1'b1; ihit = 1'b0;
        #1;
        checks++; if (ctl !== C_DRAIN || halt !== 1'b0)
            $display("FAIL drain_edge1: got %b halt %b expected %b halt 0", ctl, halt, C_DRAIN); else passed++;
        tick();
        checks++; if (ctl !== C_DRAIN || halt !== 1'b0)
            $display("FAIL drain_edge2: got %b halt %b expected %b halt 0", ctl, halt, C_DRAIN); else passed++;
        tick();
        checks++; if (ctl !== C_RESET || halt !== 1'b1)
            $display("FAIL halted_edge3: got %b halt %b expected %b halt 1", ctl, halt, C_RESET); else passed++;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (halt !== 1'b1 || ctl !== C_RESET)
            $display("FAIL halt_sticky: got %b halt %b expected %b halt 1", ctl, halt, C_RESET); else passed++;
        checks++; if (flush_cnt !== 4'd0) $display("FAIL flush_cnt_halted: got %0d expected 0", flush_cnt); else passed++;
        idle();
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        halt_MEM = 1'b1;
        tick();
        halt_MEM = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        checks++; if (ctl !== C_NORM || halt !== 1'b0)
            $display("FAIL reset_mid_drain: got %b halt %b expected %b halt 0", ctl, halt, C_NORM); else passed++;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (halt !== 1'b0 || ctl !== C_NORM)
            $display("FAIL post_reset_run: got %b halt %b expected %b halt 0", ctl, halt, C_NORM); else passed++;
    endtask

    initial begin
        test_reset();
        test_lduse();
        test_ihit();
        test_dwait_redirect();
        test_redirect_priority();
        test_counters();
        test_halt();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
